// File: rtl/aes_pkg.sv
// Shared AES constants for the decryption datapath: field arithmetic helpers,
// affine constants, the FIPS-197 inverse S-Box table and the InvSubBytes FSM encoding.
package aes_pkg;

    localparam int AES_NB_BYTE  = 8;
    localparam int AES_NB_STATE = 128;

    localparam logic [7:0] AES_POLY        = 8'h1b;
    localparam logic [7:0] INV_AFFINE_CONST = 8'h05;
    localparam logic [7:0] FWD_AFFINE_CONST = 8'h63;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_e;

    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // GF(2^8) multiply, shift-and-add reduced by the AES polynomial.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ aa;
            end else begin
                acc = acc;
            end
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ AES_POLY) : {aa[6:0], 1'b0};
        end
        return acc;
    endfunction

    // Inverse as a^254 = product of a^(2^i), i = 1..7; maps 0 to 0 for free.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ INV_AFFINE_CONST;
    endfunction

endpackage

// File: rtl/inv_byte_substitution_state_if.sv
// Valid/ready bus between inverse ShiftRows, the InvSubBytes engine and AddRoundKey.
interface inv_byte_substitution_state_if;
    import aes_pkg::*;

    logic [AES_NB_STATE-1:0] i_state;
    logic                    i_valid;
    logic                    o_ready;
    logic [AES_NB_STATE-1:0] o_state;
    logic                    o_valid;
    logic                    i_ready;

    modport slave (
        input  i_state,
        input  i_valid,
        output o_ready,
        output o_state,
        output o_valid,
        input  i_ready
    );

    modport master (
        output i_state,
        output i_valid,
        input  o_ready,
        input  o_state,
        input  o_valid,
        output i_ready
    );

endinterface

// File: rtl/inv_byte_substitution_state_algorithm.sv
// Combinational single-byte InvSbox. INV_SBOX_ROM_EN selects the FIPS-197 table
// instead of inverse-affine plus GF(2^8) inversion; both give identical results.
module inv_byte_substitution_algorithm
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

`ifdef INV_SBOX_ROM_EN
    // Table lookup lane.
    always_comb begin
        o_byte = INV_SBOX[i_byte];
    end
`else
    logic [7:0] affine_s;

    // Undo the affine transform first, then invert in the field.
    always_comb begin
        affine_s = inv_affine(i_byte);
        o_byte   = gf_inv(affine_s);
    end
`endif

endmodule

// File: rtl/inv_byte_substitution_state.sv
// InvSubBytes engine: NB_PARALLEL bytes per beat over 16/NB_PARALLEL beats, result held
// until taken downstream. Build macro INV_SBOX_ROM_EN switches lanes to table lookup.
module inv_byte_substitution_state
    import aes_pkg::*;
#(
    parameter int NB_BYTE     = 8,
    parameter int NB_STATE    = 128,
    parameter int NB_PARALLEL = 4
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    inv_byte_substitution_state_if.slave bus
);

    localparam bit PAR_OK   = (NB_PARALLEL == 1) || (NB_PARALLEL == 2) || (NB_PARALLEL == 4) ||
                              (NB_PARALLEL == 8) || (NB_PARALLEL == 16);
    localparam bit BAD_CONF = (NB_BYTE != 8) || (NB_STATE != 128) || !PAR_OK;
    localparam int NB_BEATS = PAR_OK ? (16 / NB_PARALLEL) : 1;
    localparam int NB_CHUNK = AES_NB_BYTE * NB_PARALLEL;
    localparam logic [3:0] LAST_CNT = 4'(NB_BEATS - 1);

    if (BAD_CONF) begin : g_bad_conf
        $error("inv_byte_substitution_state: illegal NB_BYTE/NB_STATE/NB_PARALLEL");
    end

    fsm_state_e              state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [AES_NB_STATE-1:0] work_q, work_d;
    logic                    o_valid_q, o_valid_d;
    logic                    ready_s;
    logic [NB_CHUNK-1:0]     chunk_in_s;
    logic [NB_CHUNK-1:0]     chunk_out_s;

    // Slice of the work register handled in the current beat.
    always_comb begin
        chunk_in_s = work_q[int'(cnt_q) * NB_CHUNK +: NB_CHUNK];
    end

    for (genvar l = 0; l < NB_PARALLEL; l++) begin : g_lane
        inv_byte_substitution_algorithm u_alg (
            .i_byte (chunk_in_s[l * AES_NB_BYTE +: AES_NB_BYTE]),
            .o_byte (chunk_out_s[l * AES_NB_BYTE +: AES_NB_BYTE])
        );
    end

    // Next-state, beat counter and work register update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        ready_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_s = 1'b1;
                if (bus.i_valid) begin
                    work_d  = bus.i_state;
                    cnt_d   = 4'd0;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                work_d[int'(cnt_q) * NB_CHUNK +: NB_CHUNK] = chunk_out_s;
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = 4'd0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                // A consumer handshake frees the slot, so a waiting upstream state may enter now.
                if (bus.i_ready) begin
                    ready_s = 1'b1;
                    if (bus.i_valid) begin
                        work_d  = bus.i_state;
                        cnt_d   = 4'd0;
                        state_d = ST_BUSY;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = ST_IDLE;
            end
        endcase
        o_valid_d = (state_d == ST_DONE);
    end

    // State, counter, data and valid registers with synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            work_q    <= {AES_NB_STATE{1'b0}};
            o_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            o_valid_q <= o_valid_d;
        end
    end

    assign bus.o_ready = ready_s & ~i_reset;
    assign bus.o_valid = o_valid_q;
    assign bus.o_state = work_q;

endmodule

// File: tb/tb_inv_byte_substitution_state.sv
// Randomised self-checking bench for inv_byte_substitution_state across NB_PARALLEL 1/2/4/16.
module tb_inv_byte_substitution_state;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [7:0] sbox_f [256];
    logic [7:0] sbox_i [256];

    inv_byte_substitution_state_if bus_p1 ();
    inv_byte_substitution_state_if bus_p2 ();
    inv_byte_substitution_state_if bus_p4 ();
    inv_byte_substitution_state_if bus_p16 ();

    inv_byte_substitution_state #(.NB_PARALLEL(1))  u_p1  (.i_clock(clk), .i_reset(rst), .bus(bus_p1.slave));
    inv_byte_substitution_state #(.NB_PARALLEL(2))  u_p2  (.i_clock(clk), .i_reset(rst), .bus(bus_p2.slave));
    inv_byte_substitution_state #(.NB_PARALLEL(4))  u_p4  (.i_clock(clk), .i_reset(rst), .bus(bus_p4.slave));
    inv_byte_substitution_state #(.NB_PARALLEL(16)) u_p16 (.i_clock(clk), .i_reset(rst), .bus(bus_p16.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int fmul(input int a, input int b);
        int r;
        int x;
        r = 0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (((b >> i) & 1) == 1) r = r ^ x;
            x = x << 1;
            if ((x & 256) != 0) x = x ^ 283;
        end
        return r;
    endfunction

    function automatic int rotl8(input int v, input int n);
        return ((v << n) | (v >> (8 - n))) & 255;
    endfunction

    // Forward S-Box from brute-force field inverse plus forward affine; InvSbox is its inverse table.
    task automatic build_model();
        int inv;
        int s;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++) if (fmul(x, y) == 1) inv = y;
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 99;
            sbox_f[x] = 8'(s);
            sbox_i[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] ref_state(input logic [127:0] s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = sbox_i[s[8*k +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand_state();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_bus(input virtual inv_byte_substitution_state_if vif);
        vif.i_state = 128'h0;
        vif.i_valid = 1'b0;
        vif.i_ready = 1'b0;
    endtask

    task automatic accept(input virtual inv_byte_substitution_state_if vif, input logic [127:0] st, input string tag);
        int n;
        vif.i_state = st;
        vif.i_valid = 1'b1;
        #1;
        n = 0;
        while (vif.o_ready !== 1'b1 && n < 40) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (vif.o_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_accept: o_ready=%b required 1", tag, vif.o_ready);
        end
        @(posedge clk);
        #1;
        vif.i_valid = 1'b0;
    endtask

    task automatic wait_valid(input virtual inv_byte_substitution_state_if vif, input int lat,
                              input logic [127:0] exp, input string tag);
        int n;
        n = 1;
        while (vif.o_valid !== 1'b1 && n < lat + 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != lat || vif.o_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles (o_valid=%b) required %0d", tag, n, vif.o_valid, lat);
        end
        checks++;
        if (vif.o_state !== exp) begin
            errors++;
            $display("FAIL %s_data: got %h required %h", tag, vif.o_state, exp);
        end
    endtask

    task automatic drain(input virtual inv_byte_substitution_state_if vif, input string tag);
        vif.i_ready = 1'b1;
        tick();
        vif.i_ready = 1'b0;
        checks++;
        if (vif.o_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain: o_valid=%b required 0", tag, vif.o_valid);
        end
    endtask

    task automatic check_in_reset(input virtual inv_byte_substitution_state_if vif, input string tag);
        checks++;
        if (vif.o_valid !== 1'b0 || vif.o_state !== 128'h0 || vif.o_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_reset: o_valid=%b o_ready=%b o_state=%h required 0/0/0",
                     tag, vif.o_valid, vif.o_ready, vif.o_state);
        end
    endtask

    task automatic check_after_reset(input virtual inv_byte_substitution_state_if vif, input string tag);
        checks++;
        if (vif.o_ready !== 1'b1 || vif.o_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_post_reset: o_ready=%b o_valid=%b required 1/0", tag, vif.o_ready, vif.o_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        check_in_reset(bus_p1, "p1");
        check_in_reset(bus_p2, "p2");
        check_in_reset(bus_p4, "p4");
        check_in_reset(bus_p16, "p16");
        rst = 1'b0;
        #1;
        check_after_reset(bus_p1, "p1");
        check_after_reset(bus_p2, "p2");
        check_after_reset(bus_p4, "p4");
        check_after_reset(bus_p16, "p16");
    endtask

    task automatic test_all_63();
        accept(bus_p4, {16{8'h63}}, "all63");
        wait_valid(bus_p4, 5, 128'h0, "all63");
        drain(bus_p4, "all63");
    endtask

    task automatic test_known_bytes();
        accept(bus_p1, {{12{8'h63}}, 8'h16, 8'hed, 8'h7c, 8'h00}, "known");
        wait_valid(bus_p1, 17, {96'h0, 8'hff, 8'h53, 8'h01, 8'h52}, "known");
        drain(bus_p1, "known");
    endtask

    task automatic test_exhaustive();
        logic [7:0] v;
        logic       ok;
        for (int i = 0; i < 256; i++) begin
            v = 8'(i);
            accept(bus_p16, {16{v}}, "sweep");
            wait_valid(bus_p16, 2, {16{sbox_i[v]}}, "sweep");
            ok = 1'b1;
            for (int k = 0; k < 16; k++) if (sbox_f[bus_p16.o_state[8*k +: 8]] !== v) ok = 1'b0;
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL sweep_fwd: v=%h o_state=%h does not map back", v, bus_p16.o_state);
            end
            drain(bus_p16, "sweep");
        end
    endtask

    task automatic run_random(input virtual inv_byte_substitution_state_if vif, input int lat, input string tag);
        logic [127:0] st;
        for (int i = 0; i < 8; i++) begin
            st = rand_state();
            accept(vif, st, tag);
            wait_valid(vif, lat, ref_state(st), tag);
            drain(vif, tag);
        end
    endtask

    task automatic test_random();
        run_random(bus_p1, 17, "rand_p1");
        run_random(bus_p2, 9, "rand_p2");
        run_random(bus_p4, 5, "rand_p4");
        run_random(bus_p16, 2, "rand_p16");
    endtask

    task automatic test_backpressure();
        logic [127:0] a;
        logic [127:0] b;
        a = rand_state();
        b = rand_state();
        accept(bus_p2, a, "bp1");
        wait_valid(bus_p2, 9, ref_state(a), "bp1");
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (bus_p2.o_valid !== 1'b1 || bus_p2.o_state !== ref_state(a) || bus_p2.o_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d o_valid=%b o_ready=%b o_state=%h required 1/0/%h",
                         i, bus_p2.o_valid, bus_p2.o_ready, bus_p2.o_state, ref_state(a));
            end
        end
        bus_p2.i_state = b;
        bus_p2.i_valid = 1'b1;
        bus_p2.i_ready = 1'b1;
        #1;
        checks++;
        if (bus_p2.o_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_handoff_ready: o_ready=%b required 1", bus_p2.o_ready);
        end
        tick();
        bus_p2.i_valid = 1'b0;
        bus_p2.i_ready = 1'b0;
        wait_valid(bus_p2, 9, ref_state(b), "bp2");
        drain(bus_p2, "bp2");
    endtask

    task automatic test_back_to_back();
        logic [127:0] a;
        logic [127:0] b;
        int n;
        a = rand_state();
        b = rand_state();
        accept(bus_p4, a, "b2b1");
        bus_p4.i_state = b;
        bus_p4.i_valid = 1'b1;
        #1;
        n = 1;
        while (bus_p4.o_valid !== 1'b1 && n < 30) begin
            checks++;
            if (bus_p4.o_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_busy_ready: o_ready=%b required 0", bus_p4.o_ready);
            end
            tick();
            n++;
        end
        checks++;
        if (n != 5 || bus_p4.o_state !== ref_state(a)) begin
            errors++;
            $display("FAIL b2b_first: latency %0d state %h required 5 %h", n, bus_p4.o_state, ref_state(a));
        end
        bus_p4.i_ready = 1'b1;
        #1;
        checks++;
        if (bus_p4.o_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_handoff_ready: o_ready=%b required 1", bus_p4.o_ready);
        end
        tick();
        bus_p4.i_valid = 1'b0;
        bus_p4.i_ready = 1'b0;
        wait_valid(bus_p4, 5, ref_state(b), "b2b2");
        drain(bus_p4, "b2b2");
    endtask

    task automatic test_reset_mid_busy();
        logic [127:0] c;
        accept(bus_p4, rand_state(), "rstmid");
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (bus_p4.o_ready !== 1'b0 || bus_p4.o_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_during: o_ready=%b o_valid=%b required 0/0", bus_p4.o_ready, bus_p4.o_valid);
        end
        tick();
        rst = 1'b0;
        #1;
        check_after_reset(bus_p4, "rstmid");
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (bus_p4.o_valid !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_no_valid: cycle %0d o_valid=%b required 0", i, bus_p4.o_valid);
            end
        end
        c = rand_state();
        accept(bus_p4, c, "rstmid_next");
        wait_valid(bus_p4, 5, ref_state(c), "rstmid_next");
        drain(bus_p4, "rstmid_next");
    endtask

    task automatic test_idle_ready();
        bus_p1.i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus_p1.o_valid !== 1'b0 || bus_p1.o_ready !== 1'b1) begin
                errors++;
                $display("FAIL idle_iready: o_valid=%b o_ready=%b required 0/1", bus_p1.o_valid, bus_p1.o_ready);
            end
        end
        bus_p1.i_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        init_bus(bus_p1);
        init_bus(bus_p2);
        init_bus(bus_p4);
        init_bus(bus_p16);
        build_model();
        test_reset();
        test_all_63();
        test_known_bytes();
        test_exhaustive();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_busy();
        test_idle_ready();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
